// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg: state codes, reset-target codes and output decode shared by the run controller
package cpu_run_ctrl_pkg;
  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_RUN  = 3'd1,
    S_HALT = 3'd2,
    S_STEP = 3'd3,
    S_LOAD = 3'd4
  } state_t;
  typedef enum logic {
    T_RUN  = 1'b0,
    T_HALT = 1'b1
  } tgt_t;
  localparam int HOLD_W = 4;
  function automatic logic commits(state_t s);
    return s == S_RUN || s == S_STEP;
  endfunction
endpackage

// File: rtl/cpu_ld_port.sv
// cpu_ld_port: loader handshake; registers one word per request and pulses ack/we the following cycle
module cpu_ld_port #(
  parameter int WIDTH      = 13,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      data,
  output logic                  ack,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [WIDTH-1:0]      wdata
);
  logic take;
  // a request still high during its own ack cycle is the word just written
  assign take = en && req && !ack;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack   <= 1'b0;
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      ack <= take;
      we  <= take;
      if (take) begin
        waddr <= addr;
        wdata <= data;
      end
    end
  end
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/halt/step/load sequencer owning the core commit enable and core reset
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int WIDTH      = 13,
  parameter int ADDR_WIDTH = 8,
  parameter int RST_HOLD   = 2,
  parameter int BOOT_RUN   = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_rst,
  input  logic                  dbg_halt,
  input  logic                  dbg_run,
  input  logic                  dbg_step,
  input  logic                  ld_req,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [WIDTH-1:0]      ld_data,
  output logic                  ld_ack,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [WIDTH-1:0]      imem_wdata,
  output logic                  commit_en,
  output logic                  core_rst,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  retired
);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD - 1);
  localparam tgt_t BOOT_TGT = (BOOT_RUN != 0) ? T_RUN : T_HALT;
  state_t            state;
  tgt_t              tgt;
  logic [HOLD_W-1:0] hold;
  assign core_rst  = state == S_RST;
  assign commit_en = commits(state);
  assign halted    = state == S_HALT;
  cpu_ld_port #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ld (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == S_LOAD),
    .req   (ld_req),
    .addr  (ld_addr),
    .data  (ld_data),
    .ack   (ld_ack),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_RST;
      tgt     <= BOOT_TGT;
      hold    <= HOLD_INIT;
      retired <= '0;
    end else begin
      retired <= core_rst ? '0 : retired + CNT_WIDTH'(commit_en);
      case (state)
        S_RST:
          if (hold == '0) state <= (dbg_halt || tgt == T_HALT) ? S_HALT : S_RUN;
          else hold <= hold - 1'b1;
        S_RUN:
          if (id_rst) begin
            state <= S_RST;
            hold  <= HOLD_INIT;
            tgt   <= dbg_halt ? T_HALT : T_RUN;
          end else if (dbg_halt) state <= S_HALT;
        S_HALT:
          state <= ld_req ? S_LOAD : dbg_step ? S_STEP : (dbg_run && !dbg_halt) ? S_RUN : S_HALT;
        S_STEP: begin
          state <= id_rst ? S_RST : S_HALT;
          hold  <= HOLD_INIT;
          tgt   <= T_HALT;
        end
        S_LOAD:
          // leave only once the last accepted word has been written
          if (!ld_req && !imem_we) begin
            state <= S_RST;
            hold  <= HOLD_INIT;
            tgt   <= T_HALT;
          end
        default: state <= S_RST;
      endcase
    end
  end
endmodule
